core_switch_ctrl: RTL

- Downstream consumer of two pulse_detection instances, one per core (A = primary, B = backup).
- Takes each core's heartbeat health flag and decides which core drives the shared outputs.
- Failover is registered, with holdoff to suppress flapping.
- Reports switch events and a dual-failure fault to the rest of the switch fabric.

---
 rtl/core_switch_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/core_switch_ctrl.sv
// Primary/backup core selector: health-driven failover with holdoff, manual force and fault report.
// Optional CORE_SWITCH_AUTO_REVERT_EN: return from B to A after A has been healthy for a full holdoff.
module core_switch_ctrl #(
    parameter int unsigned PERIOD     = 14745,
    parameter int unsigned HOLDOFF_MS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ok_a,
    input  logic        ok_b,
    input  logic        force_req,
    input  logic        force_sel,
    output logic        sel,
    output logic        a_active,
    output logic        b_active,
    output logic        fault,
    output logic        switch_pulse,
    output logic [15:0] switch_count
);

    localparam logic [31:0] HOLD_CYCLES = HOLDOFF_MS * PERIOD;

    typedef enum logic [1:0] {
        INIT,
        ACT_A,
        ACT_B,
        NONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sel_nxt;
    logic [31:0] holdoff;
    logic        expired;
    logic        entering;

    assign expired  = (holdoff == '0);
    assign entering = ((state_nxt == ACT_A) || (state_nxt == ACT_B)) && (state_nxt != state);

`ifdef CORE_SWITCH_AUTO_REVERT_EN
    logic [31:0] qual;
    logic        revert;

    // qual counts earlier consecutive ok_a samples in ACT_B; this sample completes the run
    assign revert = ok_a && (qual >= HOLD_CYCLES - 32'd1);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if (ok_a)      state_nxt = ACT_A;
                else if (ok_b) state_nxt = ACT_B;
                else           state_nxt = NONE;
            end
            ACT_A: begin
                if (!ok_a && !ok_b)                    state_nxt = NONE;
                else if (!ok_a && ok_b && expired)     state_nxt = ACT_B;
                else if (force_req && force_sel && ok_b) state_nxt = ACT_B;
            end
            ACT_B: begin
                if (!ok_a && !ok_b)                      state_nxt = NONE;
                else if (!ok_b && ok_a && expired)       state_nxt = ACT_A;
                else if (force_req && !force_sel && ok_a) state_nxt = ACT_A;
`ifdef CORE_SWITCH_AUTO_REVERT_EN
                else if (revert && expired)              state_nxt = ACT_A;
`endif
            end
            NONE: begin
                // Prefer staying on the current core so a simultaneous recovery causes no switch
                if (sel ? ok_b : ok_a)  state_nxt = sel ? ACT_B : ACT_A;
                else if (ok_a)          state_nxt = ACT_A;
                else if (ok_b)          state_nxt = ACT_B;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        sel_nxt = sel;
        if (state_nxt == ACT_A)      sel_nxt = 1'b0;
        else if (state_nxt == ACT_B) sel_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= INIT;
            sel          <= 1'b0;
            a_active     <= 1'b0;
            b_active     <= 1'b0;
            fault        <= 1'b0;
            switch_pulse <= 1'b0;
            switch_count <= '0;
            holdoff      <= '0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            a_active     <= (state_nxt == ACT_A);
            b_active     <= (state_nxt == ACT_B);
            fault        <= (state_nxt == NONE);
            switch_pulse <= (sel_nxt != sel);
            if ((sel_nxt != sel) && (switch_count != '1))
                switch_count <= switch_count + 16'd1;
            if (entering)
                holdoff <= HOLD_CYCLES;
            else if (!expired)
                holdoff <= holdoff - 32'd1;
        end
    end

`ifdef CORE_SWITCH_AUTO_REVERT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qual <= '0;
        end else if ((state == ACT_B) && (state_nxt == ACT_B) && ok_a) begin
            if (qual != HOLD_CYCLES)
                qual <= qual + 32'd1;
        end else begin
            qual <= '0;
        end
    end
`endif

endmodule
